// File: rtl/serial_bus_port.sv
// Multi-channel parallel-to-serial transmit port: arbitrates posted channel words onto a BUS_W-bit bus, MS beat first.
// Latency: ch_load at t -> ch_busy at t+1 -> first beat valid at t+2; one idle cycle between words.
// Backpressure: ard_receive_ready=0 holds the current beat indefinitely; a load to a busy channel is dropped and flags error.
module serial_bus_port #(
    parameter int DATA_W  = 16,
    parameter int BUS_W   = 8,
    parameter int NUM_CH  = 3,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_load,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_done,
    input  logic                     ard_receive_ready,
    output logic [BUS_W-1:0]         out_bus,
    output logic                     out_valid,
    output logic [NUM_CH-1:0]        bus_sel,
    output logic                     error,
    input  logic                     err_clr
);
    localparam int BEATS  = DATA_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   sel;
    logic [DATA_W-1:0]   hold [NUM_CH];
    logic [DATA_W-1:0]   shreg;
    logic [BEAT_W-1:0]   beat;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    gnt;
    logic                err_q;

    logic                last_beat;
    logic [NUM_CH-1:0]   accept;
    logic                overrun;
    logic                any_pend;
    logic [PTR_W-1:0]    win;

    assign last_beat = (state == SEND) && ard_receive_ready && (beat == BEAT_W'(BEATS - 1));
    assign ch_done   = last_beat ? sel : '0;
    // A channel finishing this cycle may be reloaded in the same cycle without an overrun.
    assign accept    = ch_load & (~pending | ch_done);
    assign overrun   = |(ch_load & pending & ~ch_done);

    assign ch_busy   = pending;
    assign out_valid = (state == SEND);
    assign out_bus   = out_valid ? shreg[DATA_W-1 -: BUS_W] : '0;
    assign bus_sel   = sel;
    assign error     = err_q;

    always_comb begin
        int start;
        int idx;
        any_pend = 1'b0;
        win      = '0;
        idx      = 0;
        start    = (RR_MODE != 0) ? int'(ptr) : 0;
        // Scan downwards so the first pending index from start is the last one to assign.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (start + k) % NUM_CH;
            if (pending[idx]) begin
                any_pend = 1'b1;
                win      = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            sel     <= '0;
            shreg   <= '0;
            beat    <= '0;
            ptr     <= '0;
            gnt     <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) hold[i] <= ch_data[i*DATA_W +: DATA_W];
            end
            pending <= (pending & ~ch_done) | accept;

            if (overrun)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_pend) begin
                        shreg <= hold[win];
                        beat  <= '0;
                        gnt   <= win;
                        sel   <= NUM_CH'(1) << win;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (ard_receive_ready) begin
                        if (last_beat) begin
                            sel   <= '0;
                            ptr   <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + PTR_W'(1);
                            state <= IDLE;
                        end else begin
                            shreg <= shreg << BUS_W;
                            beat  <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bus_port.sv
// Bench for serial_bus_port: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a per-instance transaction-level model.
module tb_serial_bus_port;
    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int N     = 3;
    localparam int BEATS = DW / BW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  ch_load = '0;
    logic [N*DW-1:0] ch_data = '0;
    logic          rdy = 1'b0;
    logic          clr = 1'b0;

    logic [N-1:0]  busy  [2];
    logic [N-1:0]  done  [2];
    logic [BW-1:0] bus   [2];
    logic          valid [2];
    logic [N-1:0]  sel   [2];
    logic          err   [2];

    serial_bus_port #(.DATA_W(DW), .BUS_W(BW), .NUM_CH(N), .RR_MODE(0)) u0 (
        .clk(clk), .rst(rst), .ch_load(ch_load), .ch_data(ch_data),
        .ch_busy(busy[0]), .ch_done(done[0]), .ard_receive_ready(rdy),
        .out_bus(bus[0]), .out_valid(valid[0]), .bus_sel(sel[0]),
        .error(err[0]), .err_clr(clr));

    serial_bus_port #(.DATA_W(DW), .BUS_W(BW), .NUM_CH(N), .RR_MODE(1)) u1 (
        .clk(clk), .rst(rst), .ch_load(ch_load), .ch_data(ch_data),
        .ch_busy(busy[1]), .ch_done(done[1]), .ard_receive_ready(rdy),
        .out_bus(bus[1]), .out_valid(valid[1]), .bus_sel(sel[1]),
        .error(err[1]), .err_clr(clr));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model, one slot per instance (0 = fixed priority, 1 = round-robin)
    logic [N-1:0]  m_pend [2];
    logic [DW-1:0] m_held [2][N];
    logic [DW-1:0] m_word [2];
    logic          m_snd  [2];
    int            m_g    [2];
    int            m_beat [2];
    int            m_ptr  [2];
    logic          m_err  [2];

    logic [BW-1:0] beats0 [$];
    int            order1 [$];
    int            dones0;

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_word[m] = '0;
            m_snd[m]  = 1'b0;
            m_g[m]    = 0;
            m_beat[m] = 0;
            m_ptr[m]  = 0;
            m_err[m]  = 1'b0;
            for (int i = 0; i < N; i++) m_held[m][i] = '0;
        end
    endtask

    function automatic logic [N-1:0] exp_done(input int m);
        logic [N-1:0] one;
        one = 1;
        if (m_snd[m] && rdy && m_beat[m] == BEATS - 1) return one << m_g[m];
        return '0;
    endfunction

    task automatic model_step();
        int dch;
        int st;
        int idx;
        logic ovr;
        logic [N-1:0] acc;
        for (int m = 0; m < 2; m++) begin
            dch = (m_snd[m] && rdy && m_beat[m] == BEATS - 1) ? m_g[m] : -1;
            ovr = 1'b0;
            acc = '0;
            for (int i = 0; i < N; i++) begin
                if (ch_load[i]) begin
                    if (!m_pend[m][i] || dch == i) acc[i] = 1'b1;
                    else ovr = 1'b1;
                end
            end
            if (m_snd[m]) begin
                if (rdy) begin
                    if (m_beat[m] == BEATS - 1) begin
                        m_snd[m] = 1'b0;
                        m_ptr[m] = (m_g[m] + 1) % N;
                    end else begin
                        m_beat[m]++;
                    end
                end
            end else begin
                st = (m == 1) ? m_ptr[m] : 0;
                for (int k = 0; k < N; k++) begin
                    idx = (st + k) % N;
                    if (!m_snd[m] && m_pend[m][idx]) begin
                        m_snd[m]  = 1'b1;
                        m_g[m]    = idx;
                        m_beat[m] = 0;
                        m_word[m] = m_held[m][idx];
                    end
                end
            end
            if (dch >= 0) m_pend[m][dch] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_pend[m][i]    = 1'b1;
                    m_held[m][i]    = ch_data[i*DW +: DW];
                end
            end
            if (ovr)      m_err[m] = 1'b1;
            else if (clr) m_err[m] = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0]  esel;
        logic [BW-1:0] eb;
        logic [N-1:0]  one;
        one = 1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            esel = m_snd[m] ? (one << m_g[m]) : '0;
            eb   = m_snd[m] ? BW'(m_word[m] >> (BW * (BEATS - 1 - m_beat[m]))) : '0;
            chk("out_valid", m, 32'(valid[m]), 32'(m_snd[m]));
            chk("out_bus",   m, 32'(bus[m]),   32'(eb));
            chk("bus_sel",   m, 32'(sel[m]),   32'(esel));
            chk("ch_busy",   m, 32'(busy[m]),  32'(m_pend[m]));
            chk("ch_done",   m, 32'(done[m]),  32'(exp_done(m)));
            chk("error",     m, 32'(err[m]),   32'(m_err[m]));
        end
        if (valid[0] && rdy) beats0.push_back(bus[0]);
        if (done[0] != 0) dones0++;
        if (done[1] != 0) order1.push_back(int'(sel[1]));
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after two edges.
    task automatic do_reset();
        #2;
        rst     = 1'b0;
        ch_load = '0;
        clr     = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", m, 32'(valid[m]), 32'd0);
            chk("rst_bus",   m, 32'(bus[m]),   32'd0);
            chk("rst_sel",   m, 32'(sel[m]),   32'd0);
            chk("rst_busy",  m, 32'(busy[m]),  32'd0);
            chk("rst_done",  m, 32'(done[m]),  32'd0);
            chk("rst_err",   m, 32'(err[m]),   32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset, then idle with ready high: nothing may be sent
        do_reset();
        rdy = 1'b1;
        repeat (3) cycle();

        // Single word 0xABCD on channel 0
        beats0.delete();
        dones0 = 0;
        ch_data[15:0] = 16'hABCD;
        ch_load = 3'b001;
        cycle();
        ch_load = '0;
        repeat (5) cycle();
        chk("t2_nbeats", 0, 32'(beats0.size()), 32'd2);
        chk("t2_beat0",  0, 32'(beats0[0]), 32'h00AB);
        chk("t2_beat1",  0, 32'(beats0[1]), 32'h00CD);
        chk("t2_dones",  0, 32'(dones0), 32'd1);

        // Same word with the receiver stalling after the first beat
        beats0.delete();
        dones0 = 0;
        ch_load = 3'b001;
        cycle();
        ch_load = '0;
        cycle();
        cycle();
        rdy = 1'b0;
        repeat (3) cycle();
        rdy = 1'b1;
        repeat (3) cycle();
        chk("t3_nbeats", 0, 32'(beats0.size()), 32'd2);
        chk("t3_beat1",  0, 32'(beats0[1]), 32'h00CD);
        chk("t3_dones",  0, 32'(dones0), 32'd1);

        // Two channels posted together, fixed priority order
        beats0.delete();
        ch_data = {16'h2222, 16'h1111, 16'h0000};
        ch_load = 3'b110;
        cycle();
        ch_load = '0;
        repeat (10) cycle();
        chk("t4_nbeats", 0, 32'(beats0.size()), 32'd4);
        chk("t4_beat0",  0, 32'(beats0[0]), 32'h0011);
        chk("t4_beat2",  0, 32'(beats0[2]), 32'h0022);
        chk("t4_beat3",  0, 32'(beats0[3]), 32'h0022);

        // Round-robin with every channel reloaded in its own done cycle
        do_reset();
        rdy = 1'b1;
        ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
        ch_load = 3'b111;
        cycle();
        order1.delete();
        for (int t = 0; t < 40 && order1.size() < 5; t++) begin
            ch_load = exp_done(1);
            ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            cycle();
        end
        ch_load = '0;
        chk("t5_ngrants", 1, 32'(order1.size()), 32'd5);
        chk("t5_grant0",  1, 32'(order1[0]), 32'd1);
        chk("t5_grant1",  1, 32'(order1[1]), 32'd2);
        chk("t5_grant2",  1, 32'(order1[2]), 32'd4);
        chk("t5_grant3",  1, 32'(order1[3]), 32'd1);
        chk("t5_grant4",  1, 32'(order1[4]), 32'd2);
        chk("t5_noerr",   1, 32'(err[1]), 32'd0);

        // Overrun, error clear, then reset in the middle of a word
        do_reset();
        rdy = 1'b1;
        beats0.delete();
        ch_data[15:0] = 16'hABCD;
        ch_load = 3'b001;
        cycle();
        ch_data[15:0] = 16'h5555;
        cycle();
        ch_load = '0;
        repeat (5) cycle();
        chk("t6_err",   0, 32'(err[0]), 32'd1);
        chk("t6_beat0", 0, 32'(beats0[0]), 32'h00AB);
        chk("t6_beat1", 0, 32'(beats0[1]), 32'h00CD);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t6_errclr", 0, 32'(err[0]), 32'd0);
        ch_load = 3'b001;
        cycle();
        ch_load = '0;
        cycle();
        cycle();
        dones0 = 0;
        do_reset();
        repeat (4) cycle();
        chk("t6_nodone", 0, 32'(dones0), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) ch_load[i] = ($urandom_range(0, 3) == 0);
            ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            rdy     = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
